// File: rtl/mmio_uart_pkg.sv
// rtl/mmio_uart_pkg.sv - register offsets, STATUS bit positions and serialiser states
package mmio_uart_pkg;

   localparam logic [3:0] OFF_TXDATA = 4'h0;
   localparam logic [3:0] OFF_STATUS = 4'h4;
   localparam logic [3:0] OFF_BAUD   = 4'h8;

   localparam int ST_FULL    = 0;
   localparam int ST_EMPTY   = 1;
   localparam int ST_BUSY    = 2;
   localparam int ST_OVF     = 3;
   localparam int ST_CNT_LSB = 8;

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;

endpackage

// File: rtl/mmio_uart_tx_fifo.sv
// rtl/mmio_uart_tx_fifo.sv - synchronous FIFO; a push while full is accepted only alongside a pop
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         pop_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [AW:0]      count_q, count_d;
   logic             do_push, do_pop;

   assign full     = (count_q == (AW+1)'(DEPTH));
   assign empty    = (count_q == '0);
   assign count    = count_q;
   assign pop_data = mem_q[rd_ptr_q];
   assign do_pop   = pop && !empty;
   assign do_push  = push && (!full || do_pop);

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset: the pointers alone define what is valid.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= push_data;
   end

endmodule

// File: rtl/mmio_uart_tx.sv
// rtl/mmio_uart_tx.sv - memory-mapped transmit-only UART (8N1) with FIFO and programmable divider
module mmio_uart_tx
   import mmio_uart_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR   = 32'h0000_1000,
   parameter int          FIFO_DEPTH  = 8,
   parameter logic [15:0] DEFAULT_DIV = 16'd433
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] a,
   input  logic [31:0] wd,
   input  logic [3:0]  write_byte_enable,
   input  logic        we,
   output logic [31:0] rd,
   output logic        hit,
   output logic        tx
);

   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   tx_state_t   state_q, state_d;
   logic [15:0] baud_div_q, baud_div_d;
   logic [15:0] baud_cnt_q, baud_cnt_d;
   logic [2:0]  bit_idx_q, bit_idx_d;
   logic [7:0]  shift_q, shift_d;
   logic        ovf_q, ovf_d;
   logic        tx_q, tx_d;

   logic          wr_txdata, fifo_pop, fifo_full, fifo_empty;
   logic [7:0]    fifo_data;
   logic [CW-1:0] fifo_count;
   logic [3:0]    off;
   logic          unused_ok;

   assign hit       = (a[31:4] == BASE_ADDR[31:4]);
   assign off       = a[3:0];
   assign wr_txdata = we && hit && (off == OFF_TXDATA) && write_byte_enable[0];
   assign tx        = tx_q;
   assign unused_ok = ^{wd[31:16], write_byte_enable[3:2]};

   sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (wr_txdata),
      .push_data (wd[7:0]),
      .pop       (fifo_pop),
      .pop_data  (fifo_data),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (fifo_count)
   );

   always_comb begin
      rd = '0;
      if (hit) begin
         case (off)
            OFF_STATUS: begin
               rd[ST_FULL]             = fifo_full;
               rd[ST_EMPTY]            = fifo_empty;
               rd[ST_BUSY]             = (state_q != IDLE);
               rd[ST_OVF]              = ovf_q;
               rd[ST_CNT_LSB +: CW]    = fifo_count;
            end
            OFF_BAUD: rd[15:0] = baud_div_q;
            default:  rd = '0;
         endcase
      end
   end

   always_comb begin
      baud_div_d = baud_div_q;
      ovf_d      = ovf_q;
      if (we && hit && (off == OFF_BAUD)) begin
         if (write_byte_enable[0]) baud_div_d[7:0]  = wd[7:0];
         if (write_byte_enable[1]) baud_div_d[15:8] = wd[15:8];
      end
      if (we && hit && (off == OFF_STATUS) && write_byte_enable[0] && wd[ST_OVF])
         ovf_d = 1'b0;
      if (wr_txdata && fifo_full && !fifo_pop)
         ovf_d = 1'b1;
   end

   always_comb begin
      state_d    = state_q;
      baud_cnt_d = baud_cnt_q;
      bit_idx_d  = bit_idx_q;
      shift_d    = shift_q;
      fifo_pop   = 1'b0;
      case (state_q)
         IDLE: begin
            if (!fifo_empty) begin
               fifo_pop   = 1'b1;
               shift_d    = fifo_data;
               baud_cnt_d = baud_div_q;
               state_d    = START;
            end
         end
         START: begin
            if (baud_cnt_q == '0) begin
               baud_cnt_d = baud_div_q;
               bit_idx_d  = '0;
               state_d    = DATA;
            end else begin
               baud_cnt_d = baud_cnt_q - 1'b1;
            end
         end
         DATA: begin
            if (baud_cnt_q == '0) begin
               baud_cnt_d = baud_div_q;
               shift_d    = {1'b0, shift_q[7:1]};
               bit_idx_d  = bit_idx_q + 1'b1;
               if (bit_idx_q == 3'd7) state_d = STOP;
            end else begin
               baud_cnt_d = baud_cnt_q - 1'b1;
            end
         end
         STOP: begin
            if (baud_cnt_q == '0) begin
               if (!fifo_empty) begin
                  fifo_pop   = 1'b1;
                  shift_d    = fifo_data;
                  baud_cnt_d = baud_div_q;
                  state_d    = START;
               end else begin
                  state_d = IDLE;
               end
            end else begin
               baud_cnt_d = baud_cnt_q - 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
      // tx is registered from the upcoming state so the line changes on the transition edge
      case (state_d)
         START:   tx_d = 1'b0;
         DATA:    tx_d = shift_d[0];
         default: tx_d = 1'b1;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         baud_div_q <= DEFAULT_DIV;
         baud_cnt_q <= '0;
         bit_idx_q  <= '0;
         shift_q    <= '0;
         ovf_q      <= 1'b0;
         tx_q       <= 1'b1;
      end else begin
         state_q    <= state_d;
         baud_div_q <= baud_div_d;
         baud_cnt_q <= baud_cnt_d;
         bit_idx_q  <= bit_idx_d;
         shift_q    <= shift_d;
         ovf_q      <= ovf_d;
         tx_q       <= tx_d;
      end
   end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// tb/tb_mmio_uart_tx.sv - scoreboard bench: expected bytes queued by stimulus, serial monitor decodes tx
module tb_mmio_uart_tx;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] a = '0;
   logic [31:0] wd = '0;
   logic [3:0]  be = '0;
   logic        we = 1'b0;
   logic [31:0] rd;
   logic        hit;
   logic        tx;

   int checks = 0;
   int errors = 0;
   logic [7:0] exp_q[$];
   int  mon_div = 433;
   bit  mon_en = 1'b1;

   always #5 clk = ~clk;

   mmio_uart_tx dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .a                 (a),
      .wd                (wd),
      .write_byte_enable (be),
      .we                (we),
      .rd                (rd),
      .hit               (hit),
      .tx                (tx)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic wr(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] ben);
      @(negedge clk);
      a = addr; wd = data; be = ben; we = 1'b1;
      @(posedge clk);
      #1 we = 1'b0; be = '0;
   endtask

   task automatic rdc(input logic [31:0] addr, input logic [31:0] exp, input string name);
      @(negedge clk);
      a = addr;
      #1 chk(name, rd, exp);
   endtask

   task automatic set_div(input logic [15:0] div);
      wr(32'h1008, {16'h0, div}, 4'b0011);
      mon_div = int'(div);
   endtask

   task automatic wait_idle(input int bound, input string name);
      bit ok = 1'b0;
      for (int i = 0; i < bound && !ok; i++) begin
         @(negedge clk);
         a = 32'h1004;
         #1;
         if (rd[2] == 1'b0 && rd[1] == 1'b1) ok = 1'b1;
      end
      chk(name, {31'h0, ok}, 32'h1);
   endtask

   // Serial monitor: decodes each frame at its bit boundaries and scores it against exp_q
   int         m_d;
   bit         m_ab;
   logic [7:0] m_b;
   logic       m_stp;
   initial begin : monitor
      forever begin
         @(negedge clk);
         if (rst_n && mon_en && tx === 1'b0) begin
            m_d  = mon_div;
            m_ab = 1'b0;
            for (int j = 0; j < 8; j++) begin
               repeat (m_d + 1) @(negedge clk);
               m_b[j] = tx;
               if (!mon_en) m_ab = 1'b1;
            end
            repeat (m_d + 1) @(negedge clk);
            m_stp = tx;
            if (!mon_en) m_ab = 1'b1;
            repeat (m_d) @(negedge clk);
            if (!m_ab) begin
               if (exp_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_frame: got byte %h expected no frame", m_b);
               end else begin
                  chk("frame_byte", {24'h0, m_b}, {24'h0, exp_q.pop_front()});
                  chk("stop_bit", {31'h0, m_stp}, 32'h1);
               end
            end
         end
      end
   end

   logic [9:0]  frm;
   logic [29:0] strm, got;
   bit          low_seen;

   initial begin : stimulus
      repeat (2) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;

      rdc(32'h1004, 32'h0000_0002, "reset_status");
      chk("reset_tx", {31'h0, tx}, 32'h1);
      chk("hit_in_window", {31'h0, hit}, 32'h1);
      rdc(32'h1008, 32'd433, "reset_baud");
      rdc(32'h100C, 32'h0, "unmapped_offset");
      rdc(32'h1000, 32'h0, "txdata_reads_zero");
      @(negedge clk);
      a = 32'h0000_0FFC;
      #1;
      chk("miss_hit", {31'h0, hit}, 32'h0);
      chk("miss_rd", rd, 32'h0);

      // single frame, 4 clocks per bit
      set_div(16'd3);
      exp_q.push_back(8'hA5);
      wr(32'h1000, 32'h0000_00A5, 4'b0001);
      @(negedge clk);
      chk("a5_before_start", {31'h0, tx}, 32'h1);
      frm = {1'b1, 8'hA5, 1'b0};
      for (int k = 0; k < 10; k++) begin
         repeat ((k == 0) ? 1 : 4) @(negedge clk);
         a = 32'h1004;
         #1;
         chk($sformatf("a5_bit%0d", k), {31'h0, tx}, {31'h0, frm[k]});
         chk($sformatf("a5_busy%0d", k), {31'h0, rd[2]}, 32'h1);
      end
      repeat (3) @(negedge clk);
      rdc(32'h1004, 32'h0000_0002, "a5_idle_after_40");

      // three back-to-back frames at one clock per bit
      set_div(16'd0);
      exp_q.push_back(8'h01);
      exp_q.push_back(8'h02);
      exp_q.push_back(8'h03);
      wr(32'h1000, 32'h01, 4'b0001);
      wr(32'h1000, 32'h02, 4'b0001);
      wr(32'h1000, 32'h03, 4'b0001);
      strm = {1'b1, 8'h03, 1'b0, 1'b1, 8'h02, 1'b0, 1'b1, 8'h01, 1'b0};
      got  = strm;
      @(negedge clk);
      a = 32'h1004;
      #1;
      chk("count_after_3_writes", rd, 32'h0000_0204);
      for (int k = 1; k < 30; k++) begin
         if (k > 1) @(negedge clk);
         #1 got[k] = tx;
      end
      chk("contiguous_frames", {2'b0, got}, {2'b0, strm});
      wait_idle(50, "div0_idle");

      // overflow: one byte goes in flight, eight fill the FIFO, the tenth is dropped
      set_div(16'd100);
      for (int i = 0; i < 10; i++) begin
         if (i < 9) exp_q.push_back(8'h10 + 8'(i));
         wr(32'h1000, 32'h10 + i, 4'b0001);
      end
      rdc(32'h1004, 32'h0000_080D, "full_overflow");
      wr(32'h1004, 32'h0000_0008, 4'b0001);
      rdc(32'h1004, 32'h0000_0805, "overflow_cleared");
      wait_idle(12000, "overflow_drain");
      repeat (5) @(negedge clk);
      chk("all_frames_seen", exp_q.size(), 32'h0);

      // asynchronous reset in the middle of a data bit
      set_div(16'd3);
      exp_q.push_back(8'h3C);
      exp_q.push_back(8'h55);
      wr(32'h1000, 32'h3C, 4'b0001);
      wr(32'h1000, 32'h55, 4'b0001);
      repeat (6) @(posedge clk);
      #2;
      chk("pre_reset_tx_low", {31'h0, tx}, 32'h0);
      mon_en = 1'b0;
      exp_q.delete();
      rst_n = 1'b0;
      #1 chk("reset_async_tx", {31'h0, tx}, 32'h1);
      @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      mon_div = 433;
      rdc(32'h1004, 32'h0000_0002, "post_reset_status");
      low_seen = 1'b0;
      repeat (100) begin
         @(negedge clk);
         if (tx !== 1'b1) low_seen = 1'b1;
      end
      chk("no_frames_after_reset", {31'h0, low_seen}, 32'h0);
      mon_en = 1'b1;

      // byte-enable handling
      wr(32'h1000, 32'h0000_00AA, 4'b0010);
      rdc(32'h1004, 32'h0000_0002, "txdata_lane1_no_push");
      wr(32'h1008, 32'h0000_0500, 4'b0010);
      rdc(32'h1008, 32'h0000_05B1, "baud_lane1_only");
      wr(32'h1008, 32'h0000_FFFF, 4'b0000);
      rdc(32'h1008, 32'h0000_05B1, "baud_zero_be");
      repeat (20) @(negedge clk);
      chk("no_pending_frames", exp_q.size(), 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
